// File: rtl/bp_cache_assoc.sv
// N-way set-associative branch-predictor cache: two combinational read ports, one training write port,
// tree pseudo-LRU replacement and a one-set-per-cycle invalidation sweep. Optional macro: BP_CACHE_READ_LRU_EN.
module bp_cache_assoc #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32,
   parameter int LINES  = 128,
   parameter int WAYS   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] ra0,
   input  logic [AWIDTH-1:0] ra1,
   input  logic [AWIDTH-1:0] wa,
   input  logic [DWIDTH-1:0] din,
   input  logic              we,
   input  logic              flush,
   output logic [DWIDTH-1:0] dout0,
   output logic [DWIDTH-1:0] dout1,
   output logic              hit0,
   output logic              hit1,
   output logic              busy
);

   localparam int SETS = LINES / WAYS;
   localparam int IW   = $clog2(SETS);
   localparam int IWS  = (IW > 0) ? IW : 1;
   localparam int LW   = $clog2(WAYS);
   localparam int WWS  = (LW > 0) ? LW : 1;
   localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;
   localparam int TW   = AWIDTH - 2 - IW;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t             state_q;
   logic               busy_q;
   logic [IWS-1:0]     sidx_q;

   logic [TW-1:0]      tag_q   [SETS][WAYS];
   logic [DWIDTH-1:0]  data_q  [SETS][WAYS];
   logic [WAYS-1:0]    valid_q [SETS];
   logic [PW-1:0]      plru_q  [SETS];

   logic [IWS-1:0]     r0_idx, r1_idx, w_idx;
   logic [TW-1:0]      r0_tag, r1_tag, w_tag;
   logic [WWS-1:0]     w_way;
`ifdef BP_CACHE_READ_LRU_EN
   logic [WWS-1:0]     r0_way;
`endif

   function automatic logic [IWS-1:0] idx_of(input logic [AWIDTH-1:0] a);
      logic [AWIDTH-1:0] s;
      s = a >> 2;
      return s[IWS-1:0] & IWS'(SETS - 1);
   endfunction

   function automatic logic [TW-1:0] tag_of(input logic [AWIDTH-1:0] a);
      logic [AWIDTH-1:0] s;
      s = a >> (2 + IW);
      return s[TW-1:0];
   endfunction

   // Tree walk consumes way bits LSB first: the root splits even/odd ways; a node bit selects the LRU child.
   function automatic logic [WWS-1:0] plru_victim(input logic [PW-1:0] t);
      logic [WWS-1:0] way;
      int             node;
      way  = '0;
      node = 0;
      for (int l = 0; l < LW; l++) begin
         way[l] = t[node];
         node   = 2 * node + (t[node] ? 2 : 1);
      end
      return way;
   endfunction

   function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WWS-1:0] way);
      logic [PW-1:0] r;
      int            node;
      r    = t;
      node = 0;
      for (int l = 0; l < LW; l++) begin
         r[node] = ~way[l];
         node    = 2 * node + (way[l] ? 2 : 1);
      end
      return r;
   endfunction

   // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      r0_idx = idx_of(ra0);
      r0_tag = tag_of(ra0);
      hit0   = 1'b0;
      dout0  = '0;
`ifdef BP_CACHE_READ_LRU_EN
      r0_way = '0;
`endif
      for (int w = 0; w < WAYS; w++) begin
         if (!busy_q && valid_q[r0_idx][w] && tag_q[r0_idx][w] == r0_tag) begin
            hit0  = 1'b1;
            dout0 = data_q[r0_idx][w];
`ifdef BP_CACHE_READ_LRU_EN
            r0_way = WWS'(w);
`endif
         end
      end
   end

   always_comb begin
      r1_idx = idx_of(ra1);
      r1_tag = tag_of(ra1);
      hit1   = 1'b0;
      dout1  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!busy_q && valid_q[r1_idx][w] && tag_q[r1_idx][w] == r1_tag) begin
            hit1  = 1'b1;
            dout1 = data_q[r1_idx][w];
         end
      end
   end

   // Later assignments override earlier ones: victim < lowest invalid way < matching tag.
   always_comb begin
      w_idx = idx_of(wa);
      w_tag = tag_of(wa);
      w_way = plru_victim(plru_q[w_idx]);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w_idx][w]) w_way = WWS'(w);
      end
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w_idx][w] && tag_q[w_idx][w] == w_tag) w_way = WWS'(w);
      end
   end

   // NOTE: non-blocking assignments keep every register update based on pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= SWEEP;
         busy_q  <= 1'b1;
         sidx_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (flush) begin
                  state_q <= SWEEP;
                  busy_q  <= 1'b1;
                  sidx_q  <= '0;
               end
            end
            SWEEP: begin
               if (sidx_q == IWS'(SETS - 1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  sidx_q  <= '0;
               end else begin
                  sidx_q  <= sidx_q + 1'b1;
               end
            end
            default: begin
               state_q <= SWEEP;
               busy_q  <= 1'b1;
               sidx_q  <= '0;
            end
         endcase
      end
   end

   // NOTE: the arrays have no reset; valid and PLRU bits are cleared by the sweep, tag/data never need it.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (state_q == SWEEP) begin
            valid_q[sidx_q] <= '0;
            plru_q[sidx_q]  <= '0;
         end else begin
`ifdef BP_CACHE_READ_LRU_EN
            if (hit0) plru_q[r0_idx] <= plru_touch(plru_q[r0_idx], r0_way);
`endif
            // Issued after the read update so a same-set write replaces it.
            if (we) begin
               valid_q[w_idx][w_way] <= 1'b1;
               tag_q[w_idx][w_way]   <= w_tag;
               data_q[w_idx][w_way]  <= din;
               plru_q[w_idx]         <= plru_touch(plru_q[w_idx], w_way);
            end
         end
      end
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_bp_cache_assoc.sv
// Randomized self-checking bench for bp_cache_assoc (defaults: 128 lines, 4 ways); the reference model
// tracks per-way access timestamps and derives the tree pseudo-LRU victim from recency of each subtree.
module tb_bp_cache_assoc;

   localparam int SETS = 32;
   localparam int WAYS = 4;
   localparam logic [31:0] PARK = 32'h4;

   logic        clk, reset, we, flush;
   logic [31:0] ra0, ra1, wa, din;
   logic [31:0] dout0, dout1;
   logic        hit0, hit1, busy;

   int total = 0;
   int bad   = 0;

   bp_cache_assoc dut (
      .clk(clk), .reset(reset), .ra0(ra0), .ra1(ra1), .wa(wa), .din(din), .we(we), .flush(flush),
      .dout0(dout0), .dout1(dout1), .hit0(hit0), .hit1(hit1), .busy(busy)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   // Reference model state
   bit          m_busy = 1'b1;
   int          m_cnt  = 0;
   bit          m_valid [SETS][WAYS];
   int unsigned m_tag   [SETS][WAYS];
   logic [31:0] m_data  [SETS][WAYS];
   longint      m_last  [SETS][WAYS];
   longint      m_time  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int set_of(input logic [31:0] a);
      return int'((a >> 2) % SETS);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] a);
      return a >> 7;
   endfunction

   function automatic int m_lookup(input logic [31:0] a);
      int s;
      s = set_of(a);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) return w;
      return -1;
   endfunction

   // Each tree level halves the candidate group by one way-index bit (LSB first) and steers
   // away from the half holding the group's most recent access; an untouched group goes to half 0.
   function automatic int m_victim(input int s);
      int pre;
      pre = 0;
      for (int l = 0; l < 2; l++) begin
         longint best;
         int     bw;
         best = -1;
         bw   = -1;
         for (int w = 0; w < WAYS; w++)
            if ((w & ((1 << l) - 1)) == pre && m_last[s][w] > best) begin
               best = m_last[s][w];
               bw   = w;
            end
         if (bw >= 0 && ((bw >> l) & 1) == 0) pre |= (1 << l);
      end
      return pre;
   endfunction

   task automatic m_read(input logic [31:0] a, output logic h, output logic [31:0] d);
      int w;
      w = m_lookup(a);
      h = 1'b0;
      d = '0;
      if (!m_busy && w >= 0) begin
         h = 1'b1;
         d = m_data[set_of(a)][w];
      end
   endtask

   task automatic model_edge();
      int w, s;
      if (!reset) begin
         m_busy = 1'b1;
         m_cnt  = 0;
         return;
      end
      if (m_busy) begin
         for (int i = 0; i < WAYS; i++) begin
            m_valid[m_cnt][i] = 1'b0;
            m_last[m_cnt][i]  = -1;
         end
         m_cnt++;
         if (m_cnt == SETS) m_busy = 1'b0;
         return;
      end
      if (flush) begin
         m_busy = 1'b1;
         m_cnt  = 0;
      end
`ifdef BP_CACHE_READ_LRU_EN
      w = m_lookup(ra0);
      if (w >= 0 && !(we && set_of(wa) == set_of(ra0))) begin
         m_time++;
         m_last[set_of(ra0)][w] = m_time;
      end
`endif
      if (we) begin
         s = set_of(wa);
         w = m_lookup(wa);
         if (w < 0)
            for (int i = WAYS - 1; i >= 0; i--)
               if (!m_valid[s][i]) w = i;
         if (w < 0) w = m_victim(s);
         m_time++;
         m_valid[s][w] = 1'b1;
         m_tag[s][w]   = tag_of(wa);
         m_data[s][w]  = din;
         m_last[s][w]  = m_time;
      end
   endtask

   // Compare all outputs against the model for the current inputs, then advance one clock.
   task automatic cycle();
      logic        eh;
      logic [31:0] ed;
      #1;
      check("busy", busy, m_busy);
      m_read(ra0, eh, ed);
      check("hit0", hit0, eh);
      check("dout0", dout0, ed);
      m_read(ra1, eh, ed);
      check("hit1", hit1, eh);
      check("dout1", dout1, ed);
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wa  = a;
      din = d;
      we  = 1'b1;
      cycle();
      we  = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [31:0] a, input logic eh, input logic [31:0] ed);
      ra0 = a;
      ra1 = a;
      #1;
      check({tag, "_hit0"}, hit0, eh);
      check({tag, "_dout0"}, dout0, ed);
      check({tag, "_hit1"}, hit1, eh);
      check({tag, "_dout1"}, dout1, ed);
      ra0 = PARK;
      ra1 = PARK;
   endtask

   function automatic logic [31:0] rand_addr();
      return (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 2)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      int n;
      reset = 1'b0; we = 1'b0; flush = 1'b0;
      ra0 = '0; ra1 = '0; wa = '0; din = '0;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_last[s][w]  = -1;
         end

      // Reset held for 10 edges: busy high, both ports miss
      @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b1);
      check("rst_hit0", hit0, 1'b0);
      check("rst_hit1", hit1, 1'b0);
      check("rst_dout0", dout0, 32'h0);
      for (int i = 0; i < 9; i++) cycle();
      reset = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         check("sweep_hit0", hit0, 1'b0);
         check("sweep_hit1", hit1, 1'b0);
         cycle();
      end
      check("reset_busy_len", n, 32);

      // Write then read, including same-cycle visibility
      wa = 32'h0; din = 32'hDEADBEEF; we = 1'b1; ra0 = 32'h0; ra1 = 32'h80;
      #1;
      check("hazard_pre_hit0", hit0, 1'b0);
      cycle();
      we = 1'b0;
      #1;
      check("wr_hit0", hit0, 1'b1);
      check("wr_dout0", dout0, 32'hDEADBEEF);
      check("wr_hit1", hit1, 1'b0);
      check("wr_dout1", dout1, 32'h0);
      ra0 = PARK; ra1 = PARK;

      // Fill set 0 and evict
      wr(32'h080, 32'h080);
      wr(32'h100, 32'h100);
      wr(32'h180, 32'h180);
      wr(32'h200, 32'h200);
      rd_check("evict_000", 32'h000, 1'b0, 32'h0);
      rd_check("evict_080", 32'h080, 1'b1, 32'h080);
      rd_check("evict_100", 32'h100, 1'b1, 32'h100);
      rd_check("evict_180", 32'h180, 1'b1, 32'h180);
      rd_check("evict_200", 32'h200, 1'b1, 32'h200);

      // Same-tag overwrite
      wr(32'h080, 32'h1);
      wr(32'h080, 32'h2);
      rd_check("ovw_080", 32'h080, 1'b1, 32'h2);
      rd_check("ovw_100", 32'h100, 1'b1, 32'h100);
      rd_check("ovw_180", 32'h180, 1'b1, 32'h180);
      rd_check("ovw_200", 32'h200, 1'b1, 32'h200);

      // Flush; a write and a second flush during the sweep are both ignored
      ra0 = 32'h080; ra1 = 32'h200;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         if (n == 5) begin wa = 32'h0; din = 32'h55; we = 1'b1; end
         if (n == 6) we = 1'b0;
         if (n == 10) flush = 1'b1;
         if (n == 11) flush = 1'b0;
         check("flush_hit0", hit0, 1'b0);
         check("flush_hit1", hit1, 1'b0);
         cycle();
      end
      we = 1'b0; flush = 1'b0;
      check("flush_busy_len", n, 32);
      rd_check("flush_000", 32'h000, 1'b0, 32'h0);
      rd_check("flush_080", 32'h080, 1'b0, 32'h0);

      // Read-hit recency: only moves the victim when read-LRU is built in
      wr(32'h000, 32'hA0);
      wr(32'h080, 32'hA1);
      wr(32'h100, 32'hA2);
      wr(32'h180, 32'hA3);
      ra0 = 32'h000;
      cycle();
      ra0 = PARK;
      wr(32'h200, 32'hA4);
`ifdef BP_CACHE_READ_LRU_EN
      rd_check("rlru_000", 32'h000, 1'b1, 32'hA0);
      rd_check("rlru_080", 32'h080, 1'b0, 32'h0);
`else
      rd_check("rlru_000", 32'h000, 1'b0, 32'h0);
      rd_check("rlru_080", 32'h080, 1'b1, 32'hA1);
`endif
      rd_check("rlru_200", 32'h200, 1'b1, 32'hA4);

      // Randomized traffic with occasional flush and reset pulses
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 599) != 0);
         flush = ($urandom_range(0, 149) == 0);
         we    = 1'($urandom_range(0, 1));
         wa    = rand_addr();
         din   = $urandom();
         ra0   = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
         ra1   = rand_addr();
         cycle();
      end
      reset = 1'b1; flush = 1'b0; we = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
